// File: rtl/matmul_sequencer.sv
// rtl/matmul_sequencer.sv - operand fetch, shift-add multiply, result buffer and summation sequencer
//
// Purpose:
//   Pops operand pairs from the multiplicand/multiplier FIFOs and multiplies each
//   pair with an iterative shift-add unit, one multiplier bit per cycle. It stores
//   NUM_PROD products in a result buffer. On an add command it sums the buffer.
//   Level done flags are provided for interrupt generation.
//
// Build option:
//   SAT_ADD_EN - when defined, buffer summation is unsigned saturating.
//                When undefined, summation wraps mod 2^DATA_W.
//                Multiplication always wraps.
//
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   op_start              multiply start strobe
//   op_clear              synchronous abort/clear strobe (highest priority)
//   add_start             summation start strobe
//   a_empty/a_dout/a_rd   multiplicand FIFO (data valid the cycle after a_rd)
//   b_empty/b_dout/b_rd   multiplier FIFO (data valid the cycle after b_rd)
//   rAddr/result          combinational result buffer read port
//   sum                   summation result
//   busy                  operation in progress
//   mul_done/add_done     level completion flags

module matmul_sequencer #(
    parameter int DATA_W   = 32,
    parameter int NUM_PROD = 16,
    parameter int ADDR_W   = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              op_start,
    input  logic              op_clear,
    input  logic              add_start,
    input  logic              a_empty,
    input  logic [DATA_W-1:0] a_dout,
    output logic              a_rd,
    input  logic              b_empty,
    input  logic [DATA_W-1:0] b_dout,
    output logic              b_rd,
    input  logic [ADDR_W-1:0] rAddr,
    output logic [DATA_W-1:0] result,
    output logic [DATA_W-1:0] sum,
    output logic              busy,
    output logic              mul_done,
    output logic              add_done
);

    localparam int                BC_W        = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [ADDR_W-1:0] LP_LAST_IDX = ADDR_W'(NUM_PROD - 1);
    localparam logic [BC_W-1:0]   LP_LAST_BIT = BC_W'(DATA_W - 1);
    localparam logic [ADDR_W:0]   LP_NUM_PROD = (ADDR_W + 1)'(NUM_PROD);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LOAD,
        S_MUL,
        S_STORE,
        S_MDONE,
        S_ADD,
        S_ADONE
    } state_t;

    state_t              r_state;
    state_t              w_next;

    logic [DATA_W-1:0]   r_buf [NUM_PROD];
    logic [ADDR_W-1:0]   r_widx;
    logic [ADDR_W-1:0]   r_ridx;
    logic [DATA_W-1:0]   r_mcand;
    logic [DATA_W-1:0]   r_mplier;
    logic [DATA_W-1:0]   r_prod;
    logic [BC_W-1:0]     r_bitcnt;
    logic [DATA_W-1:0]   r_acc;
    logic [DATA_W-1:0]   r_sum;
    logic                r_mul_done;
    logic                r_add_done;

    logic                w_pop;
    logic                w_restart;
    logic                w_add_go;
    logic [DATA_W:0]     w_acc_sum;
    logic [DATA_W-1:0]   w_acc_next;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // ------------------------------------------------------------------
    // Next state and control strobes
    // ------------------------------------------------------------------
    always_comb begin
        w_next    = r_state;
        w_pop     = 1'b0;
        w_restart = 1'b0;
        w_add_go  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (op_start) begin
                    w_restart = 1'b1;
                    w_next    = S_FETCH;
                end
            end
            S_FETCH: begin
                // Both FIFOs are popped together or not at all.
                if (!a_empty && !b_empty) begin
                    w_pop  = 1'b1;
                    w_next = S_LOAD;
                end
            end
            S_LOAD: begin
                w_next = S_MUL;
            end
            S_MUL: begin
                if (r_bitcnt == LP_LAST_BIT) begin
                    w_next = S_STORE;
                end
            end
            S_STORE: begin
                w_next = (r_widx == LP_LAST_IDX) ? S_MDONE : S_FETCH;
            end
            S_MDONE, S_ADONE: begin
                if (op_start) begin
                    w_restart = 1'b1;
                    w_next    = S_FETCH;
                end else if (add_start) begin
                    w_add_go = 1'b1;
                    w_next   = S_ADD;
                end
            end
            S_ADD: begin
                if (r_ridx == LP_LAST_IDX) begin
                    w_next = S_ADONE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase

        // Clear overrides everything, including a pending pop.
        if (op_clear) begin
            w_next    = S_IDLE;
            w_pop     = 1'b0;
            w_restart = 1'b0;
            w_add_go  = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Accumulator adder: keep the carry so the saturating build can clamp.
    // Once clamped to all-ones, any further add either overflows or adds
    // zero, so the clamp persists without a separate sticky bit.
    // ------------------------------------------------------------------
    assign w_acc_sum = {1'b0, r_acc} + {1'b0, r_buf[r_ridx]};

`ifdef SAT_ADD_EN
    assign w_acc_next = w_acc_sum[DATA_W] ? {DATA_W{1'b1}} : w_acc_sum[DATA_W-1:0];
`else
    assign w_acc_next = w_acc_sum[DATA_W-1:0];
`endif

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_PROD; i++) begin
                r_buf[i] <= '0;
            end
            r_widx     <= '0;
            r_ridx     <= '0;
            r_mcand    <= '0;
            r_mplier   <= '0;
            r_prod     <= '0;
            r_bitcnt   <= '0;
            r_acc      <= '0;
            r_sum      <= '0;
            r_mul_done <= 1'b0;
            r_add_done <= 1'b0;
        end else if (op_clear) begin
            for (int i = 0; i < NUM_PROD; i++) begin
                r_buf[i] <= '0;
            end
            r_widx     <= '0;
            r_ridx     <= '0;
            r_acc      <= '0;
            r_sum      <= '0;
            r_mul_done <= 1'b0;
            r_add_done <= 1'b0;
        end else begin
            if (w_restart) begin
                r_widx     <= '0;
                r_mul_done <= 1'b0;
                r_add_done <= 1'b0;
            end
            if (w_add_go) begin
                r_ridx     <= '0;
                r_acc      <= '0;
                r_add_done <= 1'b0;
            end
            case (r_state)
                S_LOAD: begin
                    r_mcand  <= a_dout;
                    r_mplier <= b_dout;
                    r_prod   <= '0;
                    r_bitcnt <= '0;
                end
                S_MUL: begin
                    if (r_mplier[0]) begin
                        r_prod <= r_prod + r_mcand;
                    end
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_bitcnt <= r_bitcnt + 1'b1;
                end
                S_STORE: begin
                    r_buf[r_widx] <= r_prod;
                    if (r_widx == LP_LAST_IDX) begin
                        r_mul_done <= 1'b1;
                    end else begin
                        r_widx <= r_widx + 1'b1;
                    end
                end
                S_ADD: begin
                    r_acc <= w_acc_next;
                    if (r_ridx == LP_LAST_IDX) begin
                        r_sum      <= w_acc_next;
                        r_add_done <= 1'b1;
                    end else begin
                        r_ridx <= r_ridx + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign a_rd     = w_pop;
    assign b_rd     = w_pop;
    assign sum      = r_sum;
    assign mul_done = r_mul_done;
    assign add_done = r_add_done;
    assign busy     = (r_state != S_IDLE) && (r_state != S_MDONE) && (r_state != S_ADONE);
    assign result   = ({1'b0, rAddr} < LP_NUM_PROD) ? r_buf[rAddr] : '0;

endmodule

// File: tb/tb_matmul_sequencer.sv
// tb/tb_matmul_sequencer.sv - self-checking bench for matmul_sequencer
`timescale 1ns/1ps

module tb_matmul_sequencer;

    localparam int DW  = 32;
    localparam int NP  = 16;
    localparam int AW  = 4;
    localparam int LAT = NP * (DW + 3);

    logic          clk;
    logic          reset_n;
    logic          op_start;
    logic          op_clear;
    logic          add_start;
    logic          a_empty;
    logic [DW-1:0] a_dout;
    logic          a_rd;
    logic          b_empty;
    logic [DW-1:0] b_dout;
    logic          b_rd;
    logic [AW-1:0] rAddr;
    logic [DW-1:0] result;
    logic [DW-1:0] sum;
    logic          busy;
    logic          mul_done;
    logic          add_done;

    matmul_sequencer #(.DATA_W(DW), .NUM_PROD(NP), .ADDR_W(AW)) dut (
        .clk(clk), .reset_n(reset_n), .op_start(op_start), .op_clear(op_clear),
        .add_start(add_start), .a_empty(a_empty), .a_dout(a_dout), .a_rd(a_rd),
        .b_empty(b_empty), .b_dout(b_dout), .b_rd(b_rd), .rAddr(rAddr),
        .result(result), .sum(sum), .busy(busy), .mul_done(mul_done), .add_done(add_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference state
    logic [DW-1:0] qa[$];
    logic [DW-1:0] qb[$];
    logic [DW-1:0] mbuf[NP];
    int            na;
    int            nb;
    int            checks;
    int            errors;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: FIFO model pops on the edge where a_rd/b_rd were high.
    task automatic cyc();
        logic ra;
        logic rb;
        @(negedge clk);
        ra = a_rd;
        rb = b_rd;
        @(posedge clk);
        #1;
        if (ra === 1'b1) begin
            na++;
            if (qa.size() > 0) a_dout = qa.pop_front();
        end
        if (rb === 1'b1) begin
            nb++;
            if (qb.size() > 0) b_dout = qb.pop_front();
        end
        a_empty = (qa.size() == 0);
        b_empty = (qb.size() == 0);
    endtask

    task automatic push_pair(input int idx, input logic [DW-1:0] a, input logic [DW-1:0] b);
        logic [DW-1:0] p;
        p = a * b;
        qa.push_back(a);
        qb.push_back(b);
        mbuf[idx] = p;
        a_empty = 1'b0;
        b_empty = 1'b0;
    endtask

    function automatic logic [DW-1:0] sum_ref();
        logic [DW:0] s;
        s = '0;
        for (int i = 0; i < NP; i++) begin
            s = {1'b0, s[DW-1:0]} + {1'b0, mbuf[i]};
`ifdef SAT_ADD_EN
            if (s[DW]) s = {1'b0, {DW{1'b1}}};
`endif
        end
        return s[DW-1:0];
    endfunction

    task automatic start_mul();
        na = 0;
        nb = 0;
        op_start = 1'b1;
        cyc();
        op_start = 1'b0;
    endtask

    task automatic wait_mul(input int bound, output int lat);
        lat = 0;
        while (mul_done !== 1'b1 && lat < bound) begin
            cyc();
            lat++;
        end
    endtask

    task automatic wait_add(input int bound, output int lat);
        lat = 0;
        while (add_done !== 1'b1 && lat < bound) begin
            cyc();
            lat++;
        end
    endtask

    task automatic check_buf(input string tag);
        for (int i = 0; i < NP; i++) begin
            rAddr = AW'(i);
            cyc();
            chk(tag, result, mbuf[i]);
        end
    endtask

    int            lat;
    logic [DW-1:0] exp_sat;

    initial begin
        checks    = 0;
        errors    = 0;
        na        = 0;
        nb        = 0;
        reset_n   = 1'b0;
        op_start  = 1'b0;
        op_clear  = 1'b0;
        add_start = 1'b0;
        a_empty   = 1'b1;
        b_empty   = 1'b1;
        a_dout    = '0;
        b_dout    = '0;
        rAddr     = '0;
        for (int i = 0; i < NP; i++) mbuf[i] = '0;

        // Reset state
        repeat (3) cyc();
        chk("rst_busy", busy, 1'b0);
        chk("rst_mul_done", mul_done, 1'b0);
        chk("rst_add_done", add_done, 1'b0);
        chk("rst_sum", sum, '0);
        chk("rst_rd", {a_rd, b_rd}, 2'b00);
        chk("rst_result", result, '0);
        reset_n = 1'b1;
        cyc();

        // Directed run: a=i+1, b=2
        for (int i = 0; i < NP; i++) push_pair(i, DW'(i + 1), 32'd2);
        start_mul();
        chk("run1_busy", busy, 1'b1);
        wait_mul(LAT + 100, lat);
        chk("run1_latency", 64'(lat), 64'(LAT));
        chk("run1_pops_a", 64'(na), 64'(NP));
        chk("run1_pops_b", 64'(nb), 64'(NP));
        chk("run1_busy_done", busy, 1'b0);
        rAddr = 4'd5;
        cyc();
        chk("run1_result5", result, 32'd12);
        check_buf("run1_buf");

        add_start = 1'b1;
        cyc();
        add_start = 1'b0;
        chk("add1_busy", busy, 1'b1);
        wait_add(100, lat);
        chk("add1_latency", 64'(lat), 64'(NP));
        chk("add1_sum", sum, 32'd272);
        chk("add1_sum_model", sum, sum_ref());
        chk("add1_busy_done", busy, 1'b0);
        chk("add1_mul_done", mul_done, 1'b1);

        // Random run with a wrapping product at index 0, restarted from ADONE
        push_pair(0, 32'hFFFF_FFFF, 32'd2);
        for (int i = 1; i < NP; i++) push_pair(i, $urandom, $urandom);
        start_mul();
        chk("rnd_add_done_clr", add_done, 1'b0);
        wait_mul(LAT + 100, lat);
        chk("rnd_latency", 64'(lat), 64'(LAT));
        rAddr = 4'd0;
        cyc();
        chk("rnd_wrap0", result, 32'hFFFF_FFFE);
        check_buf("rnd_buf");
        add_start = 1'b1;
        cyc();
        add_start = 1'b0;
        wait_add(100, lat);
        chk("rnd_add_latency", 64'(lat), 64'(NP));
        chk("rnd_sum", sum, sum_ref());

        // Two 0x80000000 entries: wrap to 0, or saturate
        push_pair(0, 32'h8000_0000, 32'd1);
        push_pair(1, 32'h4000_0000, 32'd2);
        for (int i = 2; i < NP; i++) push_pair(i, $urandom, 32'd0);
        start_mul();
        wait_mul(LAT + 100, lat);
        chk("ovf_latency", 64'(lat), 64'(LAT));
        add_start = 1'b1;
        cyc();
        add_start = 1'b0;
        wait_add(100, lat);
`ifdef SAT_ADD_EN
        exp_sat = 32'hFFFF_FFFF;
`else
        exp_sat = 32'h0000_0000;
`endif
        chk("ovf_sum", sum, exp_sat);
        chk("ovf_sum_model", sum, sum_ref());

        // FIFO starvation after 3 pairs
        for (int i = 0; i < 3; i++) push_pair(i, $urandom, $urandom_range(0, 1000));
        start_mul();
        repeat (3 * (DW + 3) + 20) cyc();
        chk("stall_pops", 64'(na), 64'd3);
        chk("stall_busy", busy, 1'b1);
        chk("stall_mul_done", mul_done, 1'b0);
        chk("stall_rd", {a_rd, b_rd}, 2'b00);
        for (int i = 3; i < NP; i++) push_pair(i, $urandom, $urandom);
        wait_mul(LAT + 100, lat);
        chk("stall_mul_done_end", mul_done, 1'b1);
        chk("stall_pops_end", 64'(na), 64'(NP));
        chk("stall_pops_b_end", 64'(nb), 64'(NP));
        check_buf("stall_buf");

        // Clear (with simultaneous op_start) during MUL of product 7
        for (int i = 0; i < NP; i++) push_pair(i, $urandom, $urandom);
        start_mul();
        repeat (7 * (DW + 3) + 15) cyc();
        chk("clr_pre_busy", busy, 1'b1);
        op_clear = 1'b1;
        op_start = 1'b1;
        cyc();
        op_clear = 1'b0;
        op_start = 1'b0;
        chk("clr_busy", busy, 1'b0);
        chk("clr_mul_done", mul_done, 1'b0);
        chk("clr_sum", sum, '0);
        chk("clr_pops", 64'(na), 64'd8);
        for (int i = 0; i < NP; i++) mbuf[i] = '0;
        check_buf("clr_buf");
        chk("clr_stay_idle", busy, 1'b0);
        chk("clr_no_pop", 64'(na), 64'd8);
        qa.delete();
        qb.delete();
        a_empty = 1'b1;
        b_empty = 1'b1;
        cyc();

        // op_start ignored while busy, then async reset during ADD
        for (int i = 0; i < NP; i++) push_pair(i, $urandom, $urandom);
        push_pair(0, 32'd7, 32'd9);
        push_pair(0, 32'd3, 32'd5);
        qa.pop_back();
        qb.pop_back();
        qa.pop_back();
        qb.pop_back();
        mbuf[0] = qa[0] * qb[0];
        start_mul();
        repeat (100) cyc();
        op_start = 1'b1;
        cyc();
        op_start = 1'b0;
        wait_mul(LAT + 100, lat);
        chk("ign_latency", 64'(lat), 64'(LAT - 101));
        chk("ign_pops", 64'(na), 64'(NP));
        add_start = 1'b1;
        cyc();
        add_start = 1'b0;
        repeat (5) cyc();
        chk("ar_pre_busy", busy, 1'b1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("ar_sum", sum, '0);
        chk("ar_add_done", add_done, 1'b0);
        chk("ar_busy", busy, 1'b0);
        chk("ar_mul_done", mul_done, 1'b0);
        cyc();
        reset_n = 1'b1;
        cyc();
        chk("ar_idle", busy, 1'b0);
        rAddr = 4'd3;
        cyc();
        chk("ar_buf_clr", result, '0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/matmul_sequencer.md
Name: matmul_sequencer

Overview:
Sequencing controller for the matrix-multiply datapath. It sits behind the bus slave that fills the multiplicand/multiplier FIFOs and drives the start/clear strobes. On start it pops operand pairs, runs an iterative shift-add multiplier, stores the products in a result buffer, and on an add command sums the buffer. It raises level done flags that the slave uses for interrupt generation.

Parameters:
DATA_W, 32, operand/product/sum width; products and sums are kept mod 2^DATA_W
NUM_PROD, 16, products per operation; buffer depth; 2..16
ADDR_W, 4, rAddr width; 2^ADDR_W >= NUM_PROD

Ports:
clk  in  1  clock
reset_n  in  1  async active-low reset
op_start  in  1  multiply start strobe (multi_opstart)
op_clear  in  1  synchronous abort/clear strobe (multi_opclear)
add_start  in  1  summation start strobe (adder_opstart)
a_empty  in  1  multiplicand FIFO empty
a_dout  in  DATA_W  multiplicand FIFO data, valid the cycle after a_rd
a_rd  out  1  multiplicand FIFO pop
b_empty  in  1  multiplier FIFO empty
b_dout  in  DATA_W  multiplier FIFO data, valid the cycle after b_rd
b_rd  out  1  multiplier FIFO pop
rAddr  in  ADDR_W  result buffer read address
result  out  DATA_W  buf[rAddr], combinational; 0 if rAddr >= NUM_PROD
sum  out  DATA_W  summation result register
busy  out  1  high in any state except IDLE, MDONE, ADONE
mul_done  out  1  level: all products stored
add_done  out  1  level: sum valid

Behaviour:
- Reset: the interface is decided: reset reset_n, asynchronous, active-low; clock clk. All registers clear, including buffer entries, widx, sum, acc and flags. a_rd=b_rd=0, busy=0, mul_done=0, add_done=0, state IDLE.
- States: IDLE, FETCH, LOAD, MUL, STORE, MDONE, ADD, ADONE.
- IDLE: op_start=1 goes to FETCH; widx<=0, mul_done<=0, add_done<=0.
- FETCH: when !a_empty && !b_empty, pulse a_rd=b_rd=1 for exactly one cycle and go to LOAD. Otherwise wait with no pop. The two FIFOs are never popped separately.
- LOAD: mcand<=a_dout, mplier<=b_dout, prod<=0, bitcnt<=0; go to MUL.
- MUL: one bit per cycle. If mplier[0], prod<=prod+mcand. Then mcand<<=1, mplier>>=1. Exit after DATA_W cycles. Only the low DATA_W bits are kept (wraps).
- STORE: buf[widx]<=prod. If widx==NUM_PROD-1, go to MDONE with mul_done<=1. Otherwise widx++ and go to FETCH.
- Per-product latency with non-empty FIFOs: DATA_W+3 cycles. mul_done rises NUM_PROD*(DATA_W+3) cycles after the FETCH entry.
- MDONE: mul_done held. add_start=1 goes to ADD with ridx<=0, acc<=0. op_start=1 restarts as from IDLE (buffer kept, overwritten progressively).
- ADD: acc<=acc+buf[ridx], one entry per cycle, NUM_PROD cycles, mod 2^DATA_W. Then sum<=final acc, add_done<=1, go to ADONE.
- ADONE: add_done and mul_done held. op_start restarts. add_start re-runs ADD.
- Strobes are ignored in states where they are not listed, e.g. op_start while busy, or add_start in IDLE/FETCH..STORE.
- op_clear in any state: next state IDLE. Clears widx, flags, sum, and all buffer entries to 0. No FIFO pop is issued that cycle.
- Priority when strobes coincide: op_clear > op_start > add_start.
- Abort mid-operation leaves any already-popped FIFO data consumed. No re-push.
- Async reset mid-operation: immediate return to reset values.

Optional Feature:
SAT_ADD_EN
- Defined: ADD accumulation is unsigned saturating. If acc+buf[ridx] overflows DATA_W, acc clamps to all-ones and stays clamped for the rest of the pass.
- Undefined: accumulation wraps mod 2^DATA_W.
- Multiplication wraps in both builds.

Test Plan:
- Reset then 16 pairs a=i+1, b=2 preloaded; op_start -> a_rd/b_rd each pulse 16 times; mul_done rises 560 cycles after FETCH entry; result at rAddr=5 is 12.
- Same run, then add_start -> add_done after 16 cycles; sum=272; busy low in ADONE.
- Pair 0xFFFFFFFF x 2 at index 0 -> buf[0]=0xFFFFFFFE (wrap). Two entries of 0x80000000 summed -> sum=0 without SAT_ADD_EN, 0xFFFFFFFF with it.
- FIFOs empty after 3 pairs -> sequencer stalls in FETCH, busy=1, no pops. 13 more pairs pushed -> completes with mul_done=1.
- op_clear during MUL of product 7 -> IDLE next cycle, mul_done=0, result=0 at all rAddr. op_start in the same cycle as op_clear -> stays IDLE.
- reset_n asserted during ADD -> sum=0, add_done=0, busy=0 immediately; op_start ignored while busy=1 (no pops beyond the expected count).
